// File: rtl/prince_sbox_sched_pkg.sv
// Shared PRINCE S-box scheduler definitions: state encoding, default geometry, nibble index width.
package prince_sbox_sched_pkg;

  localparam int NIBBLES_DEF = 16;
  localparam int STAGES_DEF  = 3;
  localparam int IDX_W       = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FEED  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/prince_sbox_sched_valid_pipe.sv
// Valid/index delay line that tracks nibbles through the shared S-box datapath.
// Advances only on enable so it stays aligned with the datapath share registers.
module prince_valid_pipe #(
  parameter int DEPTH = 3,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             valid,
  input  logic [IDX_W-1:0] index,
  output logic             valid_out,
  output logic [IDX_W-1:0] index_out
);

  logic [DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else if (enable) begin
      vld_q[0] <= valid;
      idx_q[0] <= index;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign valid_out = vld_q[DEPTH-1];
  assign index_out = idx_q[DEPTH-1];

endmodule

// File: rtl/prince_sbox_sched.sv
// Scheduler that streams one PRINCE S-box layer, nibble by nibble, through a shared pipelined datapath.
// Optional fresh-mask stalls are enabled by defining PRINCE_SBOX_REMASK_EN.
//
// state    | meaning
// IDLE     | waiting for start
// FEED     | issuing nibbles 0..NIBBLES-1 into stage 0
// DRAIN    | all issued, waiting for the last write-back
// DONE     | one-cycle completion pulse
module prince_sbox_sched
  import prince_sbox_sched_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF,
  parameter int STAGES  = STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inv,
  input  logic             rnd_valid,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_idx,
  output logic             pipe_en,
  output logic             sbox_inv,
  output logic             wb_en,
  output logic [IDX_W-1:0] wb_idx,
  output logic             rnd_req
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic             inv_q;
  logic             active;
  logic             stall;
  logic             pipe_vld;
  logic [IDX_W-1:0] pipe_idx;

  assign active = (state == ST_FEED) || (state == ST_DRAIN);

`ifdef PRINCE_SBOX_REMASK_EN
  assign rnd_req = active;
  assign stall   = active && !rnd_valid;
`else
  logic unused_rnd_valid;
  assign unused_rnd_valid = rnd_valid;
  assign rnd_req = 1'b0;
  assign stall   = 1'b0;
`endif

  assign pipe_en  = active && !stall;
  assign rd_en    = (state == ST_FEED) && !stall;
  assign rd_idx   = rd_en ? cnt : '0;
  assign wb_en    = pipe_vld && pipe_en;
  assign wb_idx   = wb_en ? pipe_idx : '0;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign sbox_inv = inv_q;

  prince_valid_pipe #(
    .DEPTH (STAGES),
    .IDX_W (IDX_W)
  ) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .enable    (pipe_en),
    .valid     (rd_en),
    .index     (cnt),
    .valid_out (pipe_vld),
    .index_out (pipe_idx)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FEED;
      ST_FEED:  if (rd_en && (cnt == LAST_IDX)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (wb_en && (pipe_idx == LAST_IDX)) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      inv_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && start) begin
        cnt   <= '0;
        inv_q <= inv;
      end else if (rd_en) begin
        cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule
